prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the RAT program memory: receives a framed byte stream (from the UART RX path) and writes 18-bit instructions into the writable 1024x18 program memory.
- Holds the MCU in reset while a load is in progress.
- Reports completion or failure to the top level (LEDs, MCU release).

Parameters:
ADDR_WIDTH, 10, program memory address width (depth 2**ADDR_WIDTH)
DATA_WIDTH, 18, instruction width; must be 17..24
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 1_000_000, inter-byte timeout in CLK cycles (used only with the optional feature)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous active-high reset
RX_DATA  input  8  received byte
RX_VALID  input  1  RX_DATA valid
RX_READY  output  1  loader accepts byte; a transfer occurs when RX_VALID & RX_READY
WR_EN  output  1  one-cycle program memory write strobe
WR_ADDR  output  ADDR_WIDTH  write address
WR_DATA  output  DATA_WIDTH  instruction to write
MCU_HOLD  output  1  hold MCU in reset while loading
LOAD_DONE  output  1  last load completed with a good checksum
LOAD_ERR  output  1  last load failed

Behaviour:
- Reset (synchronous on CLK, active-high RST):
  - State goes to IDLE.
  - RX_READY=1; WR_EN, MCU_HOLD, LOAD_DONE, LOAD_ERR all 0.
  - WR_ADDR=0, WR_DATA=0; checksum and count registers cleared.
  - Reset asserted mid-load abandons the frame; memory already written is left as is.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then N words of 3 bytes each (B2, B1, B0, MSB first), then CHK.
  - N = {LEN_HI, LEN_LO}.
  - Word value = {B2, B1, B0}[DATA_WIDTH-1:0].
  - CHK = XOR of all word bytes only.
- States: IDLE, LEN_HI, LEN_LO, B2, B1, B0, WRITE, CHECK, DONE, ERROR.
- IDLE, DONE and ERROR behave identically toward input:
  - Any byte other than SYNC_BYTE is consumed and ignored.
  - Accepting SYNC_BYTE moves to LEN_HI and sets MCU_HOLD=1. In the same cycle it clears LOAD_DONE and LOAD_ERR, sets WR_ADDR=0 and sets checksum=0.
- LEN_HI -> LEN_LO on accept. LEN_LO -> B2 on accept.
  - N==0 or N > 2**ADDR_WIDTH -> ERROR.
- B2/B1/B0: each accepted byte is shifted into the word register and XORed into the checksum.
  - Any B2 bit at position >= DATA_WIDTH-16 that is set -> ERROR, checked on the B2 accept.
  - B0 accept -> WRITE.
- WRITE (exactly one cycle):
  - RX_READY=0, WR_EN=1, WR_DATA=word, WR_ADDR=current address.
  - Next cycle: address increments and remaining count decrements. If the count reaches 0 -> CHECK, else -> B2.
  - Write latency is 1 cycle after the B0 accept.
  - The address never wraps, because N is bounded.
- CHECK: accepted byte == checksum -> DONE, else -> ERROR.
- RX_READY is 1 in every state except WRITE.
- MCU_HOLD is 1 from the SYNC accept until entry to DONE or ERROR.
- DONE: LOAD_DONE=1, MCU_HOLD=0.
- ERROR: LOAD_ERR=1, MCU_HOLD=0. The MCU is then released with partial memory; the top level gates the release on LOAD_ERR.
- Only LEN_HI/LEN_LO/B2/B1/B0/CHECK consume bytes as frame data. A SYNC_BYTE value arriving mid-frame is treated as data (no resync).

Optional Feature:
- PROG_LOADER_TIMEOUT_EN defined:
  - A counter of TIMEOUT_CYCLES width runs in LEN_HI..CHECK and is cleared on every accepted byte.
  - Reaching TIMEOUT_CYCLES-1 -> ERROR.
- Undefined: no counter; the loader waits indefinitely for the next byte.

Decomposition:
- Shared package prog_loader_pkg holds:
  - State enum typedef.
  - Default SYNC_BYTE.
  - Frame byte-count constant (3 bytes per word).
- No sub-module needed; the optional timeout counter is inline.

Test Plan:
- RST, then frame A5 00 02 | 03 FF FF | 00 12 34 | CHK=03^FF^FF^00^12^34=0x25 -> writes:
  - 0x3FFFF at address 0, then 0x01234 at address 1.
  - Each WR_EN is a 1-cycle pulse after B0.
  - LOAD_DONE=1, MCU_HOLD=0 after CHK.
- Same frame with CHK=0x26 -> both writes occur; LOAD_ERR=1, LOAD_DONE=0.
- A5 00 00 -> ERROR after LEN_LO; no WR_EN. A5 04 01 (N=1025) -> ERROR.
- A5 00 01 04 .. -> B2=0x04 has bit 2 set -> ERROR on the B2 accept; no WR_EN.
- Bytes 55 AA then a valid 1-word frame -> 55/AA ignored. Then send a second frame after DONE -> LOAD_DONE drops on its SYNC, and the first word of the new frame is written at address 0.
- RST pulsed between B1 and B0 -> all outputs return to reset values. A subsequent complete frame then loads correctly.
- With PROG_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100: send A5 00 then idle 100 cycles -> LOAD_ERR=1, MCU_HOLD=0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the RAT program memory loader.
package prog_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_B2,
        ST_B1,
        ST_B0,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int unsigned BYTES_PER_WORD    = 3;

    // True while a frame is being received, i.e. the MCU must be held.
    function automatic logic in_frame(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_B2) ||
               (s == ST_B1) || (s == ST_B0) || (s == ST_WRITE) ||
               (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream writer for the RAT program memory; holds the MCU while loading.
// Optional inter-byte timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 18,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_DATA,
    input  logic                  RX_VALID,
    output logic                  RX_READY,
    output logic                  WR_EN,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  MCU_HOLD,
    output logic                  LOAD_DONE,
    output logic                  LOAD_ERR
);

    localparam int unsigned WORD_BITS = 8 * BYTES_PER_WORD;
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;
    // B2 bits that would land above the instruction width must be zero.
    localparam logic [7:0]  B2_MASK   = 8'(16'h00FF << (DATA_WIDTH - 16));

    if (DATA_WIDTH < 17 || DATA_WIDTH > WORD_BITS || ADDR_WIDTH > 16 ||
        TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("prog_loader: unsupported parameter set");
    end

    state_t                  state_q;
    state_t                  state_d;
    logic [7:0]              len_hi_q;
    logic [15:0]             count_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             word_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [7:0]              chk_q;
    logic                    accept;
    logic                    sync_seen;
    logic [15:0]             len_n;
    logic                    len_bad;
    logic                    tmo_hit;

    assign accept    = RX_VALID && RX_READY;
    assign sync_seen = accept && (RX_DATA == SYNC_BYTE);
    assign len_n     = {len_hi_q, RX_DATA};
    assign len_bad   = (len_n == 16'd0) || ({1'b0, len_n} > MAX_WORDS);

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_q <= '0;
        end else if (!in_frame(state_q) || accept) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign tmo_hit = in_frame(state_q) && !accept && (tmo_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (sync_seen) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept) state_d = len_bad ? ST_ERROR : ST_B2;
            end
            ST_B2: begin
                if (accept) state_d = ((RX_DATA & B2_MASK) != 8'h00) ? ST_ERROR : ST_B1;
            end
            ST_B1: begin
                if (accept) state_d = ST_B0;
            end
            ST_B0: begin
                if (accept) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = (count_q == 16'd1) ? ST_CHECK : ST_B2;
            end
            ST_CHECK: begin
                if (accept) state_d = (RX_DATA == chk_q) ? ST_DONE : ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
        if (tmo_hit) state_d = ST_ERROR;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            len_hi_q  <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            word_q    <= '0;
            wr_data_q <= '0;
            chk_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (sync_seen) begin
                        addr_q <= '0;
                        chk_q  <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) len_hi_q <= RX_DATA;
                end
                ST_LEN_LO: begin
                    if (accept) count_q <= len_n;
                end
                ST_B2, ST_B1: begin
                    if (accept) begin
                        word_q <= {word_q[7:0], RX_DATA};
                        chk_q  <= chk_q ^ RX_DATA;
                    end
                end
                ST_B0: begin
                    if (accept) begin
                        wr_data_q <= DATA_WIDTH'({word_q, RX_DATA});
                        chk_q     <= chk_q ^ RX_DATA;
                    end
                end
                ST_WRITE: begin
                    addr_q  <= addr_q + ADDR_WIDTH'(1);
                    count_q <= count_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Status flags are pure state decodes, so reset and resync clear them for free.
    assign RX_READY  = (state_q != ST_WRITE);
    assign WR_EN     = (state_q == ST_WRITE);
    assign WR_ADDR   = addr_q;
    assign WR_DATA   = wr_data_q;
    assign MCU_HOLD  = in_frame(state_q);
    assign LOAD_DONE = (state_q == ST_DONE);
    assign LOAD_ERR  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed scoreboard bench for prog_loader: expected writes queued as bytes are sent.
module tb_prog_loader;

    localparam int AW = 10;
    localparam int DW = 18;

    logic          CLK = 1'b0;
    logic          RST;
    logic [7:0]    RX_DATA;
    logic          RX_VALID;
    logic          RX_READY;
    logic          WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] WR_DATA;
    logic          MCU_HOLD;
    logic          LOAD_DONE;
    logic          LOAD_ERR;

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] sb_q[$];

    always #5 CLK = ~CLK;

    prog_loader #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .MCU_HOLD (MCU_HOLD),
        .LOAD_DONE(LOAD_DONE),
        .LOAD_ERR (LOAD_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Each write must match the oldest queued expectation; a write with nothing queued fails.
    always @(negedge CLK) begin
        if (RST === 1'b0 && WR_EN === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("write_expected", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [AW+DW-1:0] e;
                e = sb_q.pop_front();
                chk("wr_addr", 32'(WR_ADDR), 32'(e[AW+DW-1:DW]));
                chk("wr_data", 32'(WR_DATA), 32'(e[DW-1:0]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        while (RX_READY !== 1'b1 && n < 8) begin
            @(negedge CLK);
            n++;
        end
        if (n == 8) chk("rx_ready_wait", 32'(RX_READY), 32'd1);
        @(posedge CLK);
        #1;
        RX_VALID = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0,
                             input logic [AW-1:0] a);
        logic [23:0] w;
        w = {b2, b1, b0};
        sb_q.push_back({a, w[DW-1:0]});
        send_byte(b2);
        send_byte(b1);
        send_byte(b0);
    endtask

    task automatic chk_status(input string tag, input logic done, input logic err, input logic hold);
        @(negedge CLK);
        chk({tag, "_done"}, 32'(LOAD_DONE), 32'(done));
        chk({tag, "_err"},  32'(LOAD_ERR),  32'(err));
        chk({tag, "_hold"}, 32'(MCU_HOLD),  32'(hold));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(RX_READY),  32'd1);
        chk({tag, "_wren"},  32'(WR_EN),     32'd0);
        chk({tag, "_hold"},  32'(MCU_HOLD),  32'd0);
        chk({tag, "_done"},  32'(LOAD_DONE), 32'd0);
        chk({tag, "_err"},   32'(LOAD_ERR),  32'd0);
        chk({tag, "_addr"},  32'(WR_ADDR),   32'd0);
        chk({tag, "_data"},  32'(WR_DATA),   32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_values("reset");
        RST = 1'b0;

        // Good two-word frame, checksum 0x25.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        chk_status("a_loading", 1'b0, 1'b0, 1'b1);
        send_word(8'h03, 8'hFF, 8'hFF, 10'd0);
        send_word(8'h00, 8'h12, 8'h34, 10'd1);
        send_byte(8'h25);
        chk_status("a_end", 1'b1, 1'b0, 1'b0);

        // Same frame, bad checksum: writes still happen.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(8'h03, 8'hFF, 8'hFF, 10'd0);
        send_word(8'h00, 8'h12, 8'h34, 10'd1);
        send_byte(8'h26);
        chk_status("badchk", 1'b0, 1'b1, 1'b0);

        // N = 0 and N = 1025 are rejected at LEN_LO.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        chk_status("n0", 1'b0, 1'b1, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        chk_status("n1025", 1'b0, 1'b1, 1'b0);

        // N = 1024 is the largest legal length.
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        chk_status("n1024", 1'b0, 1'b0, 1'b1);
        pulse_reset();

        // B2 with bit 2 set overflows an 18-bit instruction.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h04);
        chk_status("b2ovf", 1'b0, 1'b1, 1'b0);

        // Junk bytes ignored, then a one-word frame.
        send_byte(8'h55);
        send_byte(8'hAA);
        chk_status("junk", 1'b0, 1'b1, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(8'h01, 8'h23, 8'h45, 10'd0);
        send_byte(8'h01 ^ 8'h23 ^ 8'h45);
        chk_status("one", 1'b1, 1'b0, 1'b0);

        // Second frame after DONE restarts at address 0.
        send_byte(8'hA5);
        chk_status("resync", 1'b0, 1'b0, 1'b1);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(8'h00, 8'h00, 8'h07, 10'd0);
        send_byte(8'h07);
        chk_status("second", 1'b1, 1'b0, 1'b0);

        // Reset between B1 and B0 abandons the frame.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'hAB);
        pulse_reset();
        chk_reset_values("midreset");
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(8'h01, 8'h00, 8'h01, 10'd0);
        send_word(8'h00, 8'hFF, 8'h00, 10'd1);
        send_byte(8'h01 ^ 8'h01 ^ 8'hFF);
        chk_status("after_reset", 1'b1, 1'b0, 1'b0);

        // Stall after LEN_HI.
        send_byte(8'hA5);
        send_byte(8'h00);
`ifdef PROG_LOADER_TIMEOUT_EN
        repeat (94) @(negedge CLK);
        chk_status("tmo_early", 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge CLK);
        chk_status("tmo", 1'b0, 1'b1, 1'b0);
`else
        repeat (149) @(negedge CLK);
        chk_status("no_tmo", 1'b0, 1'b0, 1'b1);
        pulse_reset();
`endif

        repeat (3) @(negedge CLK);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
